// File: rtl/imgproc_msg_reader_pkg.sv
// rtl/imgproc_msg_reader_pkg.sv - shared constants, state enum and word decode for the message reader
package imgproc_msg_reader_pkg;

  // Slave register map (word addresses)
  localparam logic [2:0] REG_STATUS = 3'd0;
  localparam logic [2:0] READ_MSG   = 3'd1;

  // Status register: number of buffered words lives in [15:8]
  localparam int USEDW_MSB = 15;
  localparam int USEDW_LSB = 8;

  // "RBY", zero-extended
  localparam logic [31:0] MSG_HEADER_DEF = 32'h00524259;

  localparam int COORD_W = 11;

  typedef enum logic [2:0] {
    POLL_WAIT,
    STAT_RD,
    STAT_CHK,
    HDR_RD,
    HDR_CHK,
    DATA_RD,
    DATA_CHK,
    OUT
  } state_e;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } coord_t;

  function automatic logic [7:0] status_usedw(input logic [31:0] word);
    return word[USEDW_MSB:USEDW_LSB];
  endfunction

  // x in [26:16], y in [10:0]; the gaps above each field are don't-care
  function automatic coord_t decode_word(input logic [31:0] word);
    coord_t c;
    c.x = word[26:16];
    c.y = word[10:0];
    return c;
  endfunction

endpackage

// File: rtl/imgproc_msg_decode.sv
// rtl/imgproc_msg_decode.sv - combinational split of a coordinate word into x and y
module imgproc_msg_decode
  import imgproc_msg_reader_pkg::*;
(
  input  logic [31:0]        word_i,
  output logic [COORD_W-1:0] x_o,
  output logic [COORD_W-1:0] y_o
);

  coord_t coord;

  assign coord = decode_word(word_i);
  assign x_o   = coord.x;
  assign y_o   = coord.y;

endmodule

// File: rtl/imgproc_msg_reader.sv
// rtl/imgproc_msg_reader.sv - Avalon-MM master draining bounding-box messages into decoded records
module imgproc_msg_reader
  import imgproc_msg_reader_pkg::*;
#(
  parameter int unsigned POLL_INTERVAL = 1000,
  parameter int unsigned MSG_WORDS     = 7,
  parameter logic [31:0] MSG_HEADER    = MSG_HEADER_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        m_chipselect,
  output logic        m_read,
  output logic [2:0]  m_address,
  input  logic [31:0] m_readdata,
  output logic        box_valid,
  input  logic        box_ready,
  output logic [10:0] r_xmin,
  output logic [10:0] r_ymin,
  output logic [10:0] r_xmax,
  output logic [10:0] r_ymax,
  output logic [10:0] b_xmin,
  output logic [10:0] b_ymin,
  output logic [10:0] b_xmax,
  output logic [10:0] b_ymax,
  output logic [10:0] y_xmin,
  output logic [10:0] y_ymin,
  output logic [10:0] y_xmax,
  output logic [10:0] y_ymax,
  output logic [7:0]  sync_err
);

  // Poll counter counts down from POLL_INTERVAL-1 so POLL_WAIT lasts exactly POLL_INTERVAL cycles
  localparam logic [10:0] POLL_LOAD = 11'(POLL_INTERVAL - 1);
  // Index of the last coordinate word (header excluded)
  localparam logic [2:0]  LAST_IDX  = 3'(MSG_WORDS - 2);

  state_e             state_q;
  logic [10:0]        poll_cnt_q;
  logic [2:0]         idx_q;
  logic               m_chipselect_q;
  logic               m_read_q;
  logic [2:0]         m_address_q;
  logic               box_valid_q;
  logic [7:0]         sync_err_q;
  logic [COORD_W-1:0] coord_q [12];

  logic [COORD_W-1:0] word_x;
  logic [COORD_W-1:0] word_y;
  logic [7:0]         usedw;

  imgproc_msg_decode u_decode (
    .word_i (m_readdata),
    .x_o    (word_x),
    .y_o    (word_y)
  );

  assign usedw = status_usedw(m_readdata);

  // Sequencer: every *_RD state strobes the bus for one cycle, every *_CHK state consumes m_readdata
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= POLL_WAIT;
      poll_cnt_q     <= '0;
      idx_q          <= '0;
      m_chipselect_q <= 1'b0;
      m_read_q       <= 1'b0;
      m_address_q    <= REG_STATUS;
      box_valid_q    <= 1'b0;
      sync_err_q     <= '0;
      for (int i = 0; i < 12; i++) begin
        coord_q[i] <= '0;
      end
    end else begin
      case (state_q)
        POLL_WAIT: begin
          if (poll_cnt_q == 11'd0) begin
            state_q        <= STAT_RD;
            m_chipselect_q <= 1'b1;
            m_read_q       <= 1'b1;
            m_address_q    <= REG_STATUS;
          end else begin
            poll_cnt_q <= poll_cnt_q - 11'd1;
          end
        end
        STAT_RD: begin
          state_q        <= STAT_CHK;
          m_chipselect_q <= 1'b0;
          m_read_q       <= 1'b0;
        end
        STAT_CHK: begin
          if ({24'd0, usedw} >= MSG_WORDS) begin
            state_q        <= HDR_RD;
            m_chipselect_q <= 1'b1;
            m_read_q       <= 1'b1;
            m_address_q    <= READ_MSG;
          end else begin
            state_q    <= POLL_WAIT;
            poll_cnt_q <= POLL_LOAD;
          end
        end
        HDR_RD: begin
          state_q        <= HDR_CHK;
          m_chipselect_q <= 1'b0;
          m_read_q       <= 1'b0;
        end
        HDR_CHK: begin
          m_chipselect_q <= 1'b1;
          m_read_q       <= 1'b1;
          if (m_readdata == MSG_HEADER) begin
            idx_q       <= '0;
            state_q     <= DATA_RD;
            m_address_q <= READ_MSG;
          end else begin
            // One word is dropped; re-check the fill level before trying the next one as a header
            if (sync_err_q != 8'hFF) begin
              sync_err_q <= sync_err_q + 8'd1;
            end
            state_q     <= STAT_RD;
            m_address_q <= REG_STATUS;
          end
        end
        DATA_RD: begin
          state_q        <= DATA_CHK;
          m_chipselect_q <= 1'b0;
          m_read_q       <= 1'b0;
        end
        DATA_CHK: begin
          coord_q[{idx_q, 1'b0}] <= word_x;
          coord_q[{idx_q, 1'b1}] <= word_y;
          idx_q                  <= idx_q + 3'd1;
          if (idx_q == LAST_IDX) begin
            state_q     <= OUT;
            box_valid_q <= 1'b1;
          end else begin
            state_q        <= DATA_RD;
            m_chipselect_q <= 1'b1;
            m_read_q       <= 1'b1;
            m_address_q    <= READ_MSG;
          end
        end
        OUT: begin
          // Skip the poll wait after a handshake so queued messages drain back to back
          if (box_ready) begin
            box_valid_q    <= 1'b0;
            state_q        <= STAT_RD;
            m_chipselect_q <= 1'b1;
            m_read_q       <= 1'b1;
            m_address_q    <= REG_STATUS;
          end
        end
        default: begin
          state_q        <= POLL_WAIT;
          poll_cnt_q     <= '0;
          m_chipselect_q <= 1'b0;
          m_read_q       <= 1'b0;
          box_valid_q    <= 1'b0;
        end
      endcase
    end
  end

  assign m_chipselect = m_chipselect_q;
  assign m_read       = m_read_q;
  assign m_address    = m_address_q;
  assign box_valid    = box_valid_q;
  assign sync_err     = sync_err_q;

  assign r_xmin = coord_q[0];
  assign r_ymin = coord_q[1];
  assign r_xmax = coord_q[2];
  assign r_ymax = coord_q[3];
  assign b_xmin = coord_q[4];
  assign b_ymin = coord_q[5];
  assign b_xmax = coord_q[6];
  assign b_ymax = coord_q[7];
  assign y_xmin = coord_q[8];
  assign y_ymin = coord_q[9];
  assign y_xmax = coord_q[10];
  assign y_ymax = coord_q[11];

endmodule
